reg_wb_arbiter: RTL and testbench

- Shares the single register-file write port (reg_wr / address_wr / data_wr) between two writeback sources: the ALU result path and the memory-load path.
- Keeps a 16-entry pending-write scoreboard. Decode uses it to stall on RAW and WAW hazards.
- Sits between execute/memory stages and the register bank; the bank captures writes on the falling clock edge.

---
 rtl/reg_wb_arbiter.sv | 104 ++++++++++
 tb/tb_reg_wb_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: round-robin sharing of the register-file write port between
// the ALU and load paths, plus a pending-write scoreboard for decode hazard stalls.
module reg_wb_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid,
   input  logic [ADDR_WIDTH-1:0] alu_addr,
   input  logic [DATA_WIDTH-1:0] alu_data,
   output logic                  alu_ready,
   input  logic                  mem_valid,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_ready,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   input  logic                  issue_wb,
   input  logic [ADDR_WIDTH-1:0] src_ra,
   input  logic [ADDR_WIDTH-1:0] src_rb,
   output logic                  stall,
   output logic                  reg_wr,
   output logic [ADDR_WIDTH-1:0] address_wr,
   output logic [DATA_WIDTH-1:0] data_wr,
   output logic [NUM_REGS-1:0]   busy_vec,
   output logic                  idle
);

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_e;

   src_e                  last_grant_q, last_grant_d;
   logic                  reg_wr_q, reg_wr_d;
   logic [ADDR_WIDTH-1:0] address_wr_q, address_wr_d;
   logic [DATA_WIDTH-1:0] data_wr_q, data_wr_d;
   logic [NUM_REGS-1:0]   busy_q, busy_d;

   logic                  grant_alu;
   logic                  grant_mem;
   logic                  transfer;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_data;
   logic                  issue_set;

   // On a conflict the source that did not win last time takes the port.
   assign grant_alu = alu_valid && (!mem_valid || (last_grant_q == SRC_MEM));
   assign grant_mem = mem_valid && (!alu_valid || (last_grant_q == SRC_ALU));
   assign transfer  = grant_alu || grant_mem;
   assign win_addr  = grant_alu ? alu_addr : mem_addr;
   assign win_data  = grant_alu ? alu_data : mem_data;

   assign alu_ready = grant_alu;
   assign mem_ready = grant_mem;

   // Hazard check sees only registered busy bits; a write retiring this cycle does not unblock.
   assign stall = issue_valid &&
                  (busy_q[src_ra] || busy_q[src_rb] || (issue_wb && busy_q[issue_rd]));
   assign issue_set = issue_valid && issue_wb && !stall;

   always_comb begin
      last_grant_d = last_grant_q;
      reg_wr_d     = transfer;
      address_wr_d = address_wr_q;
      data_wr_d    = data_wr_q;
      busy_d       = busy_q;
      if (transfer) begin
         last_grant_d       = grant_alu ? SRC_ALU : SRC_MEM;
         address_wr_d       = win_addr;
         data_wr_d          = win_data;
         busy_d[win_addr]   = 1'b0;
      end
      // Applied after the clear so a newly issued owner keeps the register busy.
      if (issue_set) begin
         busy_d[issue_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= SRC_MEM;
         reg_wr_q     <= 1'b0;
         address_wr_q <= '0;
         data_wr_q    <= '0;
         busy_q       <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         reg_wr_q     <= reg_wr_d;
         address_wr_q <= address_wr_d;
         data_wr_q    <= data_wr_d;
         busy_q       <= busy_d;
      end
   end

   assign reg_wr     = reg_wr_q;
   assign address_wr = address_wr_q;
   assign data_wr    = data_wr_q;
   assign busy_vec   = busy_q;
   assign idle       = (busy_q == '0) && !reg_wr_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: arbitration, write latency, scoreboard hazards, async reset.
module tb_reg_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid, mem_valid, issue_valid, issue_wb;
   logic [3:0]  alu_addr, mem_addr, issue_rd, src_ra, src_rb;
   logic [31:0] alu_data, mem_data;
   logic        alu_ready, mem_ready, stall, reg_wr, idle;
   logic [3:0]  address_wr;
   logic [31:0] data_wr;
   logic [15:0] busy_vec;

   int checks = 0;
   int errors = 0;

   reg_wb_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alu_valid  (alu_valid),
      .alu_addr   (alu_addr),
      .alu_data   (alu_data),
      .alu_ready  (alu_ready),
      .mem_valid  (mem_valid),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .mem_ready  (mem_ready),
      .issue_valid(issue_valid),
      .issue_rd   (issue_rd),
      .issue_wb   (issue_wb),
      .src_ra     (src_ra),
      .src_rb     (src_rb),
      .stall      (stall),
      .reg_wr     (reg_wr),
      .address_wr (address_wr),
      .data_wr    (data_wr),
      .busy_vec   (busy_vec),
      .idle       (idle)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_wr(input string tag, input logic w, input logic [3:0] a, input logic [31:0] d);
      check({tag, "_reg_wr"}, reg_wr, w);
      check({tag, "_addr"}, address_wr, a);
      check({tag, "_data"}, data_wr, d);
   endtask

   initial begin
      rst_n = 1'b0;
      alu_valid = 0; alu_addr = 0; alu_data = 0;
      mem_valid = 0; mem_addr = 0; mem_data = 0;
      issue_valid = 0; issue_rd = 0; issue_wb = 0; src_ra = 0; src_rb = 0;
      #2;
      check_wr("rst", 1'b0, 4'd0, 32'd0);
      check("rst_busy", busy_vec, 32'h0);
      check("rst_idle", idle, 1'b1);
      check("rst_stall", stall, 1'b0);
      check("rst_ready", {alu_ready, mem_ready}, 2'b00);
      #10 rst_n = 1'b1;   // released at t=12, between edges
      tick();

      // Conflict right after reset: ALU first.
      alu_valid = 1; alu_addr = 4'd3; alu_data = 32'h11;
      mem_valid = 1; mem_addr = 4'd4; mem_data = 32'h22;
      #1;
      check("c1_ready", {alu_ready, mem_ready}, 2'b10);
      tick();
      check_wr("c1", 1'b1, 4'd3, 32'h11);
      alu_addr = 4'd6; alu_data = 32'h33;  // ALU returns with a new request
      #1;
      check("c2_ready", {alu_ready, mem_ready}, 2'b01);
      tick();
      check_wr("c2", 1'b1, 4'd4, 32'h22);
      mem_addr = 4'd8; mem_data = 32'h44;
      #1;
      check("c3_ready", {alu_ready, mem_ready}, 2'b10);
      tick();
      check_wr("c3", 1'b1, 4'd6, 32'h33);
      alu_valid = 0;
      #1;
      check("c4_ready", {alu_ready, mem_ready}, 2'b01);
      tick();
      check_wr("c4", 1'b1, 4'd8, 32'h44);
      mem_valid = 0;
      tick();
      check_wr("c_idle", 1'b0, 4'd8, 32'h44);
      check("c_idle_flag", idle, 1'b1);

      // ALU only.
      alu_valid = 1; alu_addr = 4'd5; alu_data = 32'hAA;
      #1;
      check("a_ready", {alu_ready, mem_ready}, 2'b10);
      tick();
      alu_valid = 0;
      check_wr("a1", 1'b1, 4'd5, 32'hAA);
      check("a1_idle", idle, 1'b0);
      tick();
      check_wr("a2", 1'b0, 4'd5, 32'hAA);

      // RAW stall on r7.
      issue_valid = 1; issue_rd = 4'd7; issue_wb = 1;
      #1;
      check("raw_issue_stall", stall, 1'b0);
      tick();
      check("raw_busy7", busy_vec, 32'h0080);
      issue_rd = 4'd1; src_ra = 4'd7;
      #1;
      check("raw_stall", stall, 1'b1);
      tick();
      check("raw_busy_hold", busy_vec, 32'h0080);
      alu_valid = 1; alu_addr = 4'd7; alu_data = 32'h77;
      #1;
      check("raw_no_bypass", stall, 1'b1);
      tick();
      alu_valid = 0;
      check("raw_cleared", busy_vec, 32'h0);
      check("raw_unstall", stall, 1'b0);
      issue_valid = 0; src_ra = 0;
      tick();

      // Same-cycle set and clear of r9: set wins.
      mem_valid = 1; mem_addr = 4'd9; mem_data = 32'h99;
      issue_valid = 1; issue_rd = 4'd9; issue_wb = 1;
      #1;
      check("sc_stall", stall, 1'b0);
      tick();
      mem_valid = 0; issue_valid = 0;
      check("sc_busy", busy_vec, 32'h0200);
      check_wr("sc", 1'b1, 4'd9, 32'h99);
      mem_valid = 1;
      tick();
      mem_valid = 0;
      check("sc_clear", busy_vec, 32'h0);

      // WAW on r2.
      issue_valid = 1; issue_rd = 4'd2; issue_wb = 1;
      tick();
      check("waw_busy", busy_vec, 32'h0004);
      #1;
      check("waw_stall", stall, 1'b1);
      issue_wb = 0;
      #1;
      check("waw_nowb", stall, 1'b0);
      tick();
      check("waw_nowb_busy", busy_vec, 32'h0004);

      // Build busy=0x0084 with a write in flight, then async reset.
      issue_rd = 4'd7; issue_wb = 1;
      alu_valid = 1; alu_addr = 4'd5; alu_data = 32'h55;
      tick();
      issue_valid = 0;
      check("pre_rst_busy", busy_vec, 32'h0084);
      check_wr("pre_rst", 1'b1, 4'd5, 32'h55);
      alu_addr = 4'd10; alu_data = 32'hA0;
      mem_valid = 1; mem_addr = 4'd11; mem_data = 32'hB0;
      #2 rst_n = 1'b0;
      #1;
      check_wr("arst", 1'b0, 4'd0, 32'd0);
      check("arst_busy", busy_vec, 32'h0);
      check("arst_idle", idle, 1'b1);
      check("arst_ready", {alu_ready, mem_ready}, 2'b10);
      #10;
      check("arst_held", reg_wr, 1'b0);
      rst_n = 1'b1;
      tick();
      check_wr("post_rst", 1'b1, 4'd10, 32'hA0);
      alu_valid = 0; mem_valid = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
